comparador_arbitro: RTL

//  Round-robin arbiter/sequencer sharing one external 32-bit equality comparator
//  (a == b -> 1) among N_REQ requesters. Accepts operand pairs over a valid/ready

---
 rtl/comparador_arbitro.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/comparador_arbitro.sv
// Round-robin sequencer sharing one external equality comparator among N_REQ requesters.
// Optional counters are enabled with `define COMPARADOR_ARBITRO_STATS_EN.
module comparador_arbitro #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_b_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]       cmp_a_o,
    output logic [WIDTH-1:0]       cmp_b_o,
    input  logic                   cmp_eq_i,
    output logic [N_REQ-1:0]       resp_valid_o,
    output logic                   resp_equal_o,
    output logic                   busy_o
`ifdef COMPARADOR_ARBITRO_STATS_EN
    ,
    output logic [15:0]            stat_total_o,
    output logic [15:0]            stat_equal_o
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [WIDTH-1:0]   cmp_a_q, cmp_a_d;
    logic [WIDTH-1:0]   cmp_b_q, cmp_b_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic               resp_equal_q, resp_equal_d;
    logic [N_REQ-1:0]   req_ready_s;
    logic [IDX_W-1:0]   winner_s;
    logic               found_s;
    int                 cand_s;

    // Round-robin search: first pending requester starting at ptr_q.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = (int'(ptr_q) + k) % N_REQ;
            if (!found_s && req_valid_i[cand_s]) begin
                found_s  = 1'b1;
                winner_s = IDX_W'(cand_s);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state and grant logic for the IDLE -> COMPARE -> RESPOND sequence.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_idx_d    = gnt_idx_q;
        cmp_a_d      = cmp_a_q;
        cmp_b_d      = cmp_b_q;
        resp_valid_d = '0;
        resp_equal_d = resp_equal_q;
        req_ready_s  = '0;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    req_ready_s = N_REQ'(1) << winner_s;
                    cmp_a_d     = req_a_i[winner_s*WIDTH +: WIDTH];
                    cmp_b_d     = req_b_i[winner_s*WIDTH +: WIDTH];
                    gnt_idx_d   = winner_s;
                    state_d     = S_COMPARE;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_COMPARE: begin
                resp_equal_d = cmp_eq_i;
                resp_valid_d = N_REQ'(1) << gnt_idx_q;
                state_d      = S_RESPOND;
            end
            S_RESPOND: begin
                if (gnt_idx_q == IDX_W'(N_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_idx_q + IDX_W'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_idx_q    <= '0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            resp_valid_q <= '0;
            resp_equal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            cmp_a_q      <= cmp_a_d;
            cmp_b_q      <= cmp_b_d;
            resp_valid_q <= resp_valid_d;
            resp_equal_q <= resp_equal_d;
        end
    end

    // Grant is suppressed during reset so no handshake can be taken.
    assign req_ready_o  = rst_i ? '0 : req_ready_s;
    assign cmp_a_o      = cmp_a_q;
    assign cmp_b_o      = cmp_b_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_equal_o = resp_equal_q;
    assign busy_o       = (state_q != S_IDLE);

`ifdef COMPARADOR_ARBITRO_STATS_EN
    logic [15:0] stat_total_q, stat_total_d;
    logic [15:0] stat_equal_q, stat_equal_d;

    // Saturating counters advanced once per response.
    always_comb begin
        stat_total_d = stat_total_q;
        stat_equal_d = stat_equal_q;
        if (state_q == S_RESPOND) begin
            if (stat_total_q != 16'hFFFF) begin
                stat_total_d = stat_total_q + 16'd1;
            end else begin
                stat_total_d = stat_total_q;
            end
            if (resp_equal_q && (stat_equal_q != 16'hFFFF)) begin
                stat_equal_d = stat_equal_q + 16'd1;
            end else begin
                stat_equal_d = stat_equal_q;
            end
        end else begin
            stat_total_d = stat_total_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_total_q <= 16'd0;
            stat_equal_q <= 16'd0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_equal_q <= stat_equal_d;
        end
    end

    assign stat_total_o = stat_total_q;
    assign stat_equal_o = stat_equal_q;
`endif

endmodule
